// File: rtl/ast_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
package ast_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PKT  = 1'b1
    } arb_state_t;

    // Width of an index into n items; never less than one bit.
    function automatic int ptr_w(input int n);
        return ($clog2(n) != 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ast_rr_pick.sv
// Rotating-priority picker: first set req bit at or above ptr, wrapping past N_IN-1 to 0.
module ast_rr_pick
    import ast_arb_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int PW   = ptr_w(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [N_IN-1:0] gnt,
    output logic [PW-1:0]   idx
);

    int j;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_IN;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ast_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: N_IN Avalon-ST sinks share one registered source stage.
// Define AST_ARB_PORT_TAG_EN to replace the low channel bits with the granted port index.
module ast_pkt_rr_arbiter
    import ast_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int DATA_W    = 64,
    parameter int EMPTY_W   = ($clog2(DATA_W/8) != 0) ? $clog2(DATA_W/8) : 1,
    parameter int CHANNEL_W = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN*DATA_W-1:0]    sink_data,
    input  logic [N_IN-1:0]           sink_startofpacket,
    input  logic [N_IN-1:0]           sink_endofpacket,
    input  logic [N_IN-1:0]           sink_valid,
    input  logic [N_IN*EMPTY_W-1:0]   sink_empty,
    input  logic [N_IN*CHANNEL_W-1:0] sink_channel,
    output logic [N_IN-1:0]           sink_ready,
    output logic [DATA_W-1:0]         source_data,
    output logic                      source_startofpacket,
    output logic                      source_endofpacket,
    output logic                      source_valid,
    output logic [EMPTY_W-1:0]        source_empty,
    output logic [CHANNEL_W-1:0]      source_channel,
    input  logic                      source_ready,
    output logic                      busy
);

    localparam int PW = ptr_w(N_IN);

    // Whole control state in one struct so checkers can bind to a single signal.
    typedef struct packed {
        arb_state_t      state;
        logic [N_IN-1:0] grant;
        logic [PW-1:0]   gidx;
        logic [PW-1:0]   rr_ptr;
    } arb_ctrl_t;

    arb_ctrl_t ctrl_q, ctrl_d;

    logic                 out_en, acc;
    logic [N_IN-1:0]      req, pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic [DATA_W-1:0]    g_data;
    logic                 g_sop, g_eop;
    logic [EMPTY_W-1:0]   g_empty;
    logic [CHANNEL_W-1:0] g_channel, ch_load;

    // Handshake: a beat moves when valid && ready at posedge clk. Valid never waits on ready;
    // sink_ready[g] follows out_en combinationally, so a stalled source stalls the granted sink
    // in the same cycle.
    assign out_en     = !source_valid || source_ready;
    assign req        = sink_valid & sink_startofpacket;
    assign sink_ready = (ctrl_q.state == ARB_PKT) ? (ctrl_q.grant & {N_IN{out_en}}) : '0;
    assign acc        = |(sink_valid & sink_ready);
    assign busy       = (ctrl_q.state == ARB_PKT);

    ast_rr_pick #(
        .N_IN (N_IN),
        .PW   (PW)
    ) u_pick (
        .req (req),
        .ptr (ctrl_q.rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        g_data    = '0;
        g_sop     = 1'b0;
        g_eop     = 1'b0;
        g_empty   = '0;
        g_channel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (ctrl_q.grant[i]) begin
                g_data    = sink_data[i*DATA_W +: DATA_W];
                g_sop     = sink_startofpacket[i];
                g_eop     = sink_endofpacket[i];
                g_empty   = sink_empty[i*EMPTY_W +: EMPTY_W];
                g_channel = sink_channel[i*CHANNEL_W +: CHANNEL_W];
            end
        end
    end

`ifdef AST_ARB_PORT_TAG_EN
    if (CHANNEL_W <= PW) begin : g_tag_chk
        $error("AST_ARB_PORT_TAG_EN needs CHANNEL_W wider than the port index");
    end
    assign ch_load = {g_channel[CHANNEL_W-1:PW], ctrl_q.gidx};
`else
    assign ch_load = g_channel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '{state: ARB_IDLE, grant: '0, gidx: '0, rr_ptr: '0};
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // The grant is held from SOP until the EOP beat is accepted; any mid-packet SOP passes through.
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q.state)
            ARB_IDLE: begin
                if (|req) begin
                    ctrl_d.state = ARB_PKT;
                    ctrl_d.grant = pick_gnt;
                    ctrl_d.gidx  = pick_idx;
                end
            end
            ARB_PKT: begin
                if (acc && g_eop) begin
                    ctrl_d.state  = ARB_IDLE;
                    ctrl_d.grant  = '0;
                    ctrl_d.gidx   = '0;
                    ctrl_d.rr_ptr = (ctrl_q.gidx == PW'(N_IN - 1)) ? '0 : ctrl_q.gidx + 1'b1;
                end
            end
            default: ctrl_d = ctrl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            source_valid         <= 1'b0;
            source_data          <= '0;
            source_startofpacket <= 1'b0;
            source_endofpacket   <= 1'b0;
            source_empty         <= '0;
            source_channel       <= '0;
        end else if (out_en) begin
            source_valid <= acc;
            if (acc) begin
                source_data          <= g_data;
                source_startofpacket <= g_sop;
                source_endofpacket   <= g_eop;
                source_empty         <= g_empty;
                source_channel       <= ch_load;
            end
        end
    end

endmodule
